// File: rtl/zmem_responder.sv
// zmem_responder: 16x8 data store behind valid/ready request and response channels,
// one request outstanding, with WAIT_CYCLES extra cycles of access latency.
module zmem_responder #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic              RSP_WR,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              BUSY
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0] cnt;
  assign REQ_READY = state == S_IDLE;
  assign BUSY = state != S_IDLE;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= S_IDLE;
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      RSP_VALID <= 1'b0;
      RSP_WR <= 1'b0;
      RSP_RDATA <= '0;
    end else
      case (state)
        S_IDLE:
          if (REQ_VALID) begin
            we_q <= REQ_WE;
            addr_q <= REQ_ADDR;
            wdata_q <= REQ_WDATA;
            cnt <= 4'(WAIT_CYCLES);
            state <= S_WAIT;
          end
        S_WAIT:
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            // read data comes from the store at commit time, not at accept
            if (we_q) mem[addr_q] <= wdata_q;
            RSP_RDATA <= we_q ? wdata_q : mem[addr_q];
            RSP_WR <= we_q;
            RSP_VALID <= 1'b1;
            state <= S_RESP;
          end
        S_RESP:
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            state <= S_IDLE;
          end
        default: begin
          RSP_VALID <= 1'b0;
          state <= S_IDLE;
        end
      endcase
endmodule
